// File: rtl/ovr_pkg.sv
// Shared types and constants for the override force scheduler.
package ovr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FORCE   = 2'd1,
        RELEASE = 2'd2
    } ovr_state_e;

    localparam logic [15:0] CNT_SAT = 16'hFFFF;

    // Round-robin successor of idx among n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ovr_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
module ovr_rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
    output logic [NREQ-1:0]         pick_oh_o,
    output logic [$clog2(NREQ)-1:0] pick_idx_o,
    output logic                    pick_vld_o
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    always_comb begin
        int unsigned j;
        pick_oh_o  = '0;
        pick_idx_o = '0;
        pick_vld_o = 1'b0;
        j          = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(rr_ptr_i) + i) % NREQ;
            if (!pick_vld_o && req_i[j]) begin
                pick_vld_o   = 1'b1;
                pick_idx_o   = IDX_W'(j);
                pick_oh_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ovr_force_sched.sv
// Round-robin scheduler sharing one override path onto a 3-input AND net.
// Optional OVR_FORCE_CNT_EN adds a saturating force_cycles counter output.
module ovr_force_sched
    import ovr_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned W      = 1,
    parameter int unsigned HOLD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             func_a,
    input  logic [W-1:0]             func_b,
    input  logic [W-1:0]             func_c,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        req_val,
    input  logic [NREQ*HOLD_W-1:0]   req_hold,
    input  logic [NREQ-1:0]          rel_req,
    output logic [NREQ-1:0]          gnt,
    output logic                     done,
    output logic                     forced,
    output logic [$clog2(NREQ)-1:0]  owner,
`ifdef OVR_FORCE_CNT_EN
    output logic [15:0]              force_cycles,
`endif
    output logic [W-1:0]             out
);
    localparam int unsigned IDX_W = $clog2(NREQ);

    ovr_state_e        state_q,  state_d;
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic              done_q,   done_d;
    logic              forced_q, forced_d;
    logic [IDX_W-1:0]  owner_q,  owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] cnt_q,    cnt_d;
    logic [W-1:0]      ovr_val_q, ovr_val_d;

    logic [NREQ-1:0]   arb_oh;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_vld;

    ovr_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .req_i      (req),
        .rr_ptr_i   (rr_ptr_q),
        .pick_oh_o  (arb_oh),
        .pick_idx_o (arb_idx),
        .pick_vld_o (arb_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            forced_q  <= 1'b0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            ovr_val_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            forced_q  <= forced_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            ovr_val_q <= ovr_val_d;
        end
    end

    // forced_q tracks state==FORCE so the override mux needs no decode.
    always_comb begin
        int unsigned sel;
        state_d   = state_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        forced_d  = forced_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        ovr_val_d = ovr_val_q;
        sel       = 32'(arb_idx);
        case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    owner_d   = arb_idx;
                    ovr_val_d = req_val[sel*W +: W];
                    cnt_d     = req_hold[sel*HOLD_W +: HOLD_W];
                    gnt_d     = arb_oh;
                    rr_ptr_d  = IDX_W'(rr_next(sel, NREQ));
                    forced_d  = 1'b1;
                    state_d   = FORCE;
                end
            end
            FORCE: begin
                if ((cnt_q == '0) || rel_req[owner_q]) begin
                    forced_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = RELEASE;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                forced_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

`ifdef OVR_FORCE_CNT_EN
    logic [15:0] fc_q, fc_d;

    always_comb begin
        fc_d = fc_q;
        if (forced_q && (fc_q != CNT_SAT)) begin
            fc_d = fc_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign force_cycles = fc_q;
`endif

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign forced = forced_q;
    assign owner  = owner_q;
    assign out    = forced_q ? ovr_val_q : (func_a & func_b & func_c);

endmodule

// File: tb/tb_ovr_force_sched.sv
// Directed self-checking bench for ovr_force_sched (NREQ=4, W=1, HOLD_W=8).
module tb_ovr_force_sched;

    logic        clk;
    logic        rst;
    logic [0:0]  func_a, func_b, func_c;
    logic [3:0]  req;
    logic [3:0]  req_val;
    logic [31:0] req_hold;
    logic [3:0]  rel_req;
    logic [3:0]  gnt;
    logic        done;
    logic        forced;
    logic [1:0]  owner;
    logic [0:0]  out;
`ifdef OVR_FORCE_CNT_EN
    logic [15:0] force_cycles;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    ovr_force_sched #(
        .NREQ(4), .W(1), .HOLD_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .func_a   (func_a),
        .func_b   (func_b),
        .func_c   (func_c),
        .req      (req),
        .req_val  (req_val),
        .req_hold (req_hold),
        .rel_req  (rel_req),
        .gnt      (gnt),
        .done     (done),
        .forced   (forced),
        .owner    (owner),
`ifdef OVR_FORCE_CNT_EN
        .force_cycles (force_cycles),
`endif
        .out      (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string tag, input logic [3:0] exp);
        int k;
        k = 0;
        while (gnt == 4'b0 && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 400) begin
            tick();
            k++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int exp_idx [3];
        int n;
        int k;
        rst = 1'b0; func_a = 1'b0; func_b = 1'b0; func_c = 1'b0;
        req = '0; req_val = '0; req_hold = '0; rel_req = '0;
        do_reset();

        chk("rst_forced", 32'(forced), 32'd0);
        chk("rst_gnt",    32'(gnt),    32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_owner",  32'(owner),  32'd0);
        chk("rst_out",    32'(out),    32'd0);
`ifdef OVR_FORCE_CNT_EN
        chk("rst_fc",     32'(force_cycles), 32'd0);
`endif

        // Functional pass-through.
        func_a = 1'b1; func_b = 1'b0; func_c = 1'b1; #1;
        chk("t1_out0", 32'(out), 32'd0);
        chk("t1_forced", 32'(forced), 32'd0);
        func_b = 1'b1; #1;
        chk("t1_out1", 32'(out), 32'd1);
        func_b = 1'b0; #1;

        // Requester 2 forces 1 for hold+1 = 10 cycles; later req_val change ignored.
        req_val = 4'b0100; req_hold[2*8 +: 8] = 8'd9; req = 4'b0100;
        tick();
        chk("t2_gnt",    32'(gnt),    32'd4);
        chk("t2_owner",  32'(owner),  32'd2);
        chk("t2_forced", 32'(forced), 32'd1);
        chk("t2_out_c1", 32'(out),    32'd1);
        req = '0; req_val = 4'b0000;
        for (int i = 2; i <= 10; i++) begin
            tick();
            if (i == 2) chk("t2_gnt_pulse", 32'(gnt), 32'd0);
            chk($sformatf("t2_out_c%0d", i), 32'(out), 32'd1);
        end
        tick();
        chk("t2_rel_forced", 32'(forced), 32'd0);
        chk("t2_rel_done",   32'(done),   32'd1);
        chk("t2_rel_out",    32'(out),    32'd0);
        tick();
        chk("t2_done_pulse", 32'(done),   32'd0);

        // Round robin from rr_ptr=0 over 4'b1011.
        do_reset();
        req_hold = '0; req_val = 4'b1111; req = 4'b1011;
        exp_idx[0] = 0; exp_idx[1] = 1; exp_idx[2] = 3;
        for (int g = 0; g < 3; g++) begin
            wait_gnt($sformatf("t3_gnt%0d", g), 4'(1 << exp_idx[g]));
            chk($sformatf("t3_owner%0d", g), 32'(owner), 32'(exp_idx[g]));
            chk($sformatf("t3_forced%0d", g), 32'(forced), 32'd1);
            req[exp_idx[g]] = 1'b0;
            tick();
            chk($sformatf("t3_done%0d", g), 32'(done), 32'd1);
            chk($sformatf("t3_unforced%0d", g), 32'(forced), 32'd0);
        end

        // Early release by owner 1; non-owner release ignored.
        req_val = 4'b0010; req_hold[1*8 +: 8] = 8'd200; req = 4'b0010;
        wait_gnt("t4_gnt", 4'b0010);
        req = '0; rel_req = 4'b0001;
        tick();
        chk("t4_ignore_rel0", 32'(forced), 32'd1);
        rel_req = '0;
        tick(); tick(); tick();
        chk("t4_c5_forced", 32'(forced), 32'd1);
        chk("t4_c5_out",    32'(out),    32'd1);
        rel_req = 4'b0010;
        tick();
        chk("t4_rel_forced", 32'(forced), 32'd0);
        chk("t4_rel_done",   32'(done),   32'd1);
        rel_req = '0;

        // Reset mid-FORCE.
        req_val = 4'b1111; req_hold[2*8 +: 8] = 8'd50; req = 4'b0100;
        wait_gnt("t5_gnt", 4'b0100);
        req = '0;
        chk("t5_forced_pre", 32'(forced), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_forced", 32'(forced), 32'd0);
        chk("t5_owner",  32'(owner),  32'd0);
        chk("t5_done",   32'(done),   32'd0);
        chk("t5_out",    32'(out),    32'd0);
        rst = 1'b0;
        tick();
        chk("t5_no_done", 32'(done), 32'd0);
`ifdef OVR_FORCE_CNT_EN
        chk("t5_fc_rst", 32'(force_cycles), 32'd0);
`endif

        // Two holds of 3 and 0: five forced cycles in total.
        req_hold = '0; req_hold[0 +: 8] = 8'd3; req = 4'b0011;
        wait_gnt("t6_gnt0", 4'b0001);
        req[0] = 1'b0;
        wait_done("t6_done0");
        wait_gnt("t6_gnt1", 4'b0010);
        req[1] = 1'b0;
        wait_done("t6_done1");
`ifdef OVR_FORCE_CNT_EN
        chk("t6_fc", 32'(force_cycles), 32'd5);
`endif

        // Max hold: 255 gives 256 forced cycles, no wrap.
        req_hold[2*8 +: 8] = 8'd255; req = 4'b0100;
        wait_gnt("t7_gnt", 4'b0100);
        req = '0;
        n = 1; k = 0;
        while (forced && k < 400) begin
            tick();
            if (forced) n++;
            k++;
        end
        chk("t7_cycles", 32'(n), 32'd256);
        chk("t7_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

endmodule
